// File: rtl/logical_op_pkg.sv
// Shared encodings for the logical op unit: operation select, FSM states and
// bit positions inside the 4-bit flags word.
package logical_op_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_NOT_A = 3'd2,
    OP_NOT_B = 3'd3,
    OP_XOR   = 3'd4,
    OP_NAND  = 3'd5,
    OP_NOR   = 3'd6,
    OP_XNOR  = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  localparam int FLAGS_W     = 4;
  localparam int FLAG_LO_AND = 0;
  localparam int FLAG_LO_OR  = 1;
  localparam int FLAG_NOT_A  = 2;
  localparam int FLAG_NOT_B  = 3;

endpackage

// File: rtl/logical_eval.sv
// Purpose: evaluate one logical op on the truth values of a and b, plus flags.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module logical_eval
  import logical_op_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  output logic               result,
  output logic [FLAGS_W-1:0] flags
);

  logic ta;
  logic tb;

  assign ta = |a;
  assign tb = |b;

  always_comb begin
    flags              = '0;
    flags[FLAG_LO_AND] = ta & tb;
    flags[FLAG_LO_OR]  = ta | tb;
    flags[FLAG_NOT_A]  = ~ta;
    flags[FLAG_NOT_B]  = ~tb;

    result = 1'b0;
    case (op_e'(op))
      OP_AND:   result = ta & tb;
      OP_OR:    result = ta | tb;
      OP_NOT_A: result = ~ta;
      OP_NOT_B: result = ~tb;
      OP_XOR:   result = ta ^ tb;
      OP_NAND:  result = ~(ta & tb);
      OP_NOR:   result = ~(ta | tb);
      OP_XNOR:  result = ~(ta ^ tb);
      default:  result = 1'b0;
    endcase
  end

endmodule

// File: rtl/logical_op_unit.sv
// Purpose: logical op per beat, optionally folded over a frame (all/any/count).
// Latency: 1 cycle from the producing beat (single or frame-last) to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; a stalled result blocks all beats.
module logical_op_unit
  import logical_op_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       flags,
  output logic             result,
  output logic             frame_all,
  output logic             frame_any,
  output logic [CNT_W-1:0] true_cnt,
  output logic             cnt_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               beat_res;
  logic [FLAGS_W-1:0] beat_flags;

  logical_eval #(.WIDTH(WIDTH)) u_eval (
    .a      (a),
    .b      (b),
    .op     (op),
    .result (beat_res),
    .flags  (beat_flags)
  );

  state_e           state_q, state_d;
  logic             acc_all_q, acc_any_q, acc_sat_q;
  logic [CNT_W-1:0] acc_cnt_q;

  logic             accept, produce, acc_load, cnt_lost;
  logic             nxt_all, nxt_any, nxt_sat;
  logic [CNT_W-1:0] nxt_cnt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    produce  = 1'b0;
    acc_load = 1'b0;
    cnt_lost = 1'b0;
    nxt_all  = beat_res;
    nxt_any  = beat_res;
    nxt_cnt  = CNT_W'(beat_res);
    nxt_sat  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (acc_en && !last) begin
            acc_load = 1'b1;
            state_d  = ST_ACCUM;
          end else begin
            produce = 1'b1;
          end
        end
      end
      ST_ACCUM: begin
        // Fold this beat into the running frame; the count sticks at max.
        cnt_lost = beat_res && (acc_cnt_q == CNT_MAX);
        nxt_all  = acc_all_q & beat_res;
        nxt_any  = acc_any_q | beat_res;
        nxt_cnt  = cnt_lost ? acc_cnt_q : acc_cnt_q + CNT_W'(beat_res);
        nxt_sat  = acc_sat_q | cnt_lost;
        if (accept) begin
          if (last) begin
            produce = 1'b1;
            state_d = ST_IDLE;
          end else begin
            acc_load = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_all_q <= 1'b0;
      acc_any_q <= 1'b0;
      acc_cnt_q <= '0;
      acc_sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc_load) begin
        acc_all_q <= nxt_all;
        acc_any_q <= nxt_any;
        acc_cnt_q <= nxt_cnt;
        acc_sat_q <= nxt_sat;
      end
    end
  end

  // Data only loads on a producing beat, which implies the old result drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= 1'b0;
      flags     <= '0;
      frame_all <= 1'b0;
      frame_any <= 1'b0;
      true_cnt  <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      if (produce) begin
        out_valid <= 1'b1;
        result    <= beat_res;
        flags     <= beat_flags;
        frame_all <= nxt_all;
        frame_any <= nxt_any;
        true_cnt  <= nxt_cnt;
        cnt_sat   <= nxt_sat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logical_op_unit.sv
// Scoreboard bench for logical_op_unit: a reference model pushes expected
// results as beats are accepted; a monitor pops them as results are taken.
module tb_logical_op_unit;
  import logical_op_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_en;
  logic             last;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       flags;
  logic             result;
  logic             frame_all;
  logic             frame_any;
  logic [CNT_W-1:0] true_cnt;
  logic             cnt_sat;

  logical_op_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .acc_en    (acc_en),
    .last      (last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flags     (flags),
    .result    (result),
    .frame_all (frame_all),
    .frame_any (frame_any),
    .true_cnt  (true_cnt),
    .cnt_sat   (cnt_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             res;
    logic [3:0]       flg;
    logic             all;
    logic             any;
    logic [CNT_W-1:0] cnt;
    logic             sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;

  bit   m_accum = 1'b0;
  bit   m_all, m_any, m_sat;
  int   m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: updated exactly when a beat is accepted.
  task automatic model_accept(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                              input logic [2:0] top, input bit ae, input bit ls,
                              output bit prod);
    bit   xa, xb, r;
    exp_t e;
    xa = (ta != 0);
    xb = (tb != 0);
    case (top)
      3'd0:    r = xa & xb;
      3'd1:    r = xa | xb;
      3'd2:    r = !xa;
      3'd3:    r = !xb;
      3'd4:    r = xa ^ xb;
      3'd5:    r = !(xa & xb);
      3'd6:    r = !(xa | xb);
      default: r = !(xa ^ xb);
    endcase
    prod = 1'b0;
    if (!m_accum) begin
      m_all = r; m_any = r; m_cnt = int'(r); m_sat = 1'b0;
      if (ae && !ls) m_accum = 1'b1;
      else prod = 1'b1;
    end else begin
      m_all = m_all & r;
      m_any = m_any | r;
      if (r) begin
        if (m_cnt == CNT_MAX) m_sat = 1'b1;
        else m_cnt++;
      end
      if (ls) begin
        m_accum = 1'b0;
        prod = 1'b1;
      end
    end
    if (prod) begin
      e.res = r;
      e.flg = {!xb, !xa, xa | xb, xa & xb};
      e.all = m_all;
      e.any = m_any;
      e.cnt = CNT_W'(m_cnt);
      e.sat = m_sat;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", exp_q.size(), 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_result", result, e.res);
        check("out_flags", flags, e.flg);
        check("out_frame_all", frame_all, e.all);
        check("out_frame_any", frame_any, e.any);
        check("out_true_cnt", true_cnt, e.cnt);
        check("out_cnt_sat", cnt_sat, e.sat);
        n_out++;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                      input logic [2:0] top, input bit ae, input bit ls);
    bit prod = 1'b0;
    bit done = 1'b0;
    a = ta; b = tb; op = top; acc_en = ae; last = ls;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(ta, tb, top, ae, ls, prod);
        done = 1'b1;
      end
    end
    if (!done) begin
      check("accept_timeout", done, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (out_ready) check("latency_out_valid", out_valid, prod);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  int n0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0; acc_en = 1'b0; last = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_true_cnt", true_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    // Single beats, then every op with random operands.
    send(4'd1, 4'd7, OP_AND, 1'b0, 1'b0);
    send(4'd0, 4'd0, OP_NOR, 1'b0, 1'b0);
    send(4'd8, 4'd3, OP_XOR, 1'b0, 1'b0);
    check("xor_result", result, 0);
    check("xor_flags", flags, 4'b0011);
    for (int i = 0; i < 8; i++)
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), 3'(i), 1'b0, 1'b0);
    drain();

    // Four-beat OR frame.
    n0 = n_out;
    send(4'd0, 4'd0, OP_OR, 1'b1, 1'b0);
    send(4'd5, 4'd0, OP_OR, 1'b1, 1'b0);
    send(4'd0, 4'd0, OP_OR, 1'b1, 1'b0);
    send(4'd2, 4'd1, OP_OR, 1'b1, 1'b1);
    drain();
    check("frame_out_count", n_out - n0, 1);
    check("frame_all", frame_all, 0);
    check("frame_any", frame_any, 1);
    check("frame_true_cnt", true_cnt, 2);
    check("frame_cnt_sat", cnt_sat, 0);

    // Stall, then back-to-back reload.
    out_ready = 1'b0;
    send(4'd3, 4'd0, OP_OR, 1'b0, 1'b0);
    check("stall_out_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_valid", out_valid, 1);
      check("stall_result", result, exp_q[0].res);
      check("stall_flags", flags, exp_q[0].flg);
      check("stall_true_cnt", true_cnt, exp_q[0].cnt);
    end
    @(posedge clk);
    #1;
    n0 = n_out;
    out_ready = 1'b1;
    send(4'd0, 4'd0, OP_AND, 1'b0, 1'b0);
    check("b2b_popped", n_out - n0, 1);
    check("b2b_result", result, 0);
    check("b2b_flags", flags, 4'b1100);
    drain();

    // Saturating count over 260 true beats.
    for (int i = 0; i < 260; i++)
      send(4'd1, 4'd0, OP_OR, 1'b1, (i == 259));
    drain();
    check("sat_true_cnt", true_cnt, CNT_MAX);
    check("sat_cnt_sat", cnt_sat, 1);
    check("sat_frame_all", frame_all, 1);

    // Reset during the second beat of a frame.
    send(4'd1, 4'd1, OP_AND, 1'b1, 1'b0);
    a = 4'd1; b = 4'd0; op = OP_OR; acc_en = 1'b1; last = 1'b0; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_flags", flags, 0);
    check("midrst_frame_all", frame_all, 0);
    check("midrst_frame_any", frame_any, 0);
    check("midrst_true_cnt", true_cnt, 0);
    check("midrst_cnt_sat", cnt_sat, 0);
    in_valid = 1'b0;
    exp_q.delete();
    m_accum = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_in_ready", in_ready, 1);
    n0 = n_out;
    send(4'd2, 4'd0, OP_OR, 1'b0, 1'b0);
    check("postrst_result", result, 1);
    check("postrst_true_cnt", true_cnt, 1);
    drain();
    check("postrst_out_count", n_out - n0, 1);

    // One-beat frame, then a plain beat must still be reported at once.
    send(4'd0, 4'd4, OP_NOT_A, 1'b1, 1'b1);
    check("onebeat_valid", out_valid, 1);
    check("onebeat_result", result, 1);
    check("onebeat_true_cnt", true_cnt, 1);
    send(4'd0, 4'd0, OP_AND, 1'b0, 1'b0);
    drain();

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/logical_op_unit.md
LOGICAL_OP_UNIT -- requirements
Module: logical_op_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the operand width in bits (min 1).
REQ-002 The block SHALL have parameter CNT_W, default 8, the width of the frame true-count (min 1).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, operand beat present.
REQ-006 The block SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH each, operands; each is logically true iff nonzero.
REQ-008 The block SHALL have port op, input, 3, operation select (decoded in REQ-015).
REQ-009 The block SHALL have port acc_en, input, 1, which starts an accumulate frame when sampled on a frame's first beat.
REQ-010 The block SHALL have port last, input, 1, marking the final beat of an accumulate frame.
REQ-011 The block SHALL have port out_valid, output, 1, result register holds valid data.
REQ-012 The block SHALL have port out_ready, input, 1, consumer takes the result.
REQ-013 The block SHALL have port flags, output, 4, {not_b, not_a, lo_or, lo_and} of the producing beat.
REQ-014 The block SHALL have ports result (1), frame_all (1), frame_any (1), true_cnt (CNT_W), cnt_sat (1), all outputs.

Function
REQ-015 The block SHALL decode op as 0 AND, 1 OR, 2 NOT_A, 3 NOT_B, 4 XOR, 5 NAND, 6 NOR, 7 XNOR, applied to the logical truth of a and b.
REQ-016 The block SHALL accept a beat on a cycle where in_valid and in_ready are both 1.
REQ-017 The block SHALL drive in_ready = !out_valid || out_ready.
REQ-018 The block SHALL implement FSM states IDLE and ACCUM.
REQ-019 In IDLE, an accepted beat with acc_en=0 SHALL load the output register on the next edge: result, flags, frame_all=result, frame_any=result, true_cnt=result, cnt_sat=0; out_valid=1 (1-cycle latency).
REQ-020 In IDLE, an accepted beat with acc_en=1 and last=0 SHALL initialise the accumulators from that beat and move to ACCUM without asserting out_valid.
REQ-021 In IDLE, an accepted beat with acc_en=1 and last=1 SHALL behave as a one-beat frame, per REQ-019, and SHALL stay in IDLE.
REQ-022 In ACCUM, acc_en SHALL be ignored; each accepted beat SHALL update frame_all &= result, frame_any |= result, and true_cnt += result.
REQ-023 true_cnt SHALL saturate at 2^CNT_W-1, and cnt_sat SHALL set when an increment is lost.
REQ-024 In ACCUM, an accepted beat with last=1 SHALL load the output register with the final accumulators plus that beat's result and flags, assert out_valid, and return to IDLE.
REQ-025 out_valid and all output data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 When out_valid=1 and out_ready=1 with a new producing beat accepted, the output register SHALL reload with no bubble; with no new producing beat, out_valid SHALL clear.
REQ-027 Accumulate beats that produce no output SHALL be accepted only when in_ready=1, so a frame cannot close while a prior result is stalled.

Reset
REQ-028 While rst_n=0, the block SHALL force state IDLE, out_valid=0, result=0, flags=0, frame_all=0, frame_any=0, true_cnt=0, cnt_sat=0, and clear accumulators asynchronously.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; the first beat after reset SHALL be treated as an IDLE beat.
REQ-030 in_ready SHALL be 1 immediately after reset release.

Structure
REQ-031 Package logical_op_pkg SHALL hold the op encoding enum, the FSM state enum, and the flags bit-index constants.
REQ-032 A combinational sub-module logical_eval (a, b, op -> result, flags) SHALL be instantiated once.

Verification
REQ-033 The bench SHALL drive, with out_ready=1 and acc_en=0: a=1,b=7 op=AND; then a=0,b=0 op=NOR; then a=8,b=3 op=XOR. Required: results 1,1,0 one cycle after each; flags 0011, 1100, 0011.
REQ-034 The bench SHALL drive frame acc_en=1, op=OR, (a,b) = (0,0),(5,0),(0,0),(2,1) with last on the 4th beat. Required: one output only, with frame_all=0, frame_any=1, true_cnt=2, cnt_sat=0.
REQ-035 The bench SHALL hold out_ready=0 with out_valid=1. Required: in_ready=0, outputs stable for 5 cycles; on out_ready=1 with a beat present, back-to-back reload.
REQ-036 The bench SHALL run a frame of 260 true beats with CNT_W=8. Required: true_cnt=255, cnt_sat=1.
REQ-037 The bench SHALL pulse rst_n low during the 2nd beat of a 4-beat frame. Required: all outputs 0 immediately; the next beat with acc_en=0 is reported alone in 1 cycle.
REQ-038 The bench SHALL drive a one-beat frame (acc_en=1, last=1, a=0, b=4, op=NOT_A). Required: result=1, true_cnt=1, FSM stays in IDLE.
